fp_in_wrapper_param: RTL
========================

Name: fp_in_wrapper_param

Overview:
Parametrised input wrapper for the floating-point datapath. It assembles NUM_OPS operands of DATA_W bits from a serial BUS_W-bit input stream using an inReady/inAccept handshake, and queues up to DEPTH complete operand sets. It presents one set at a time to the FP core, pulses startFP for each set, and retires that set on doneFP. Sits between the external input bus and the FP multiplier core.

Parameters:
DATA_W, 32, operand width in bits.
BUS_W, 32, input bus width. Must divide DATA_W; BEATS = DATA_W/BUS_W.
NUM_OPS, 2, operands per set.
DEPTH, 4, number of complete sets buffered. Must be at least 1.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
inReady  input  1  source has a valid word on inBus
inBus  input  BUS_W  input data beat
doneFP  input  1  FP core finished the current set
inAccept  output  1  wrapper can capture a beat this cycle
opBus  output  NUM_OPS*DATA_W  head set; operand i at [i*DATA_W +: DATA_W]
startFP  output  1  one-cycle start pulse to the FP core
busy  output  1  a set has been issued and is awaiting doneFP
setCount  output  $clog2(DEPTH+1)  number of complete sets queued, including the one in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: inAccept=1, startFP=0, busy=0, setCount=0, opBus=0. Reset also sets FSM=IDLE and clears the beat/operand counters and the partial assembly.
- Reset mid-operation: a partial set, all queued sets and any in-flight set are discarded. doneFP and inReady are ignored while rst=1.
- Capture: a beat transfers on a rising edge where inReady=1 and inAccept=1. No transfer when inReady=0; the partial assembly is held.
- inAccept = (setCount < DEPTH). It is combinational from registered state only; no combinational path from inReady or doneFP.
- inAccept is low when full, even if a partial set is being assembled.
- Beat order: the first beat of an operand fills its most significant BUS_W bits. Operand order: the first operand received goes to opBus[DATA_W-1:0].
- Push: the edge that captures the last beat of the last operand writes the set into the FIFO and increments setCount. Counters wrap to 0 for the next set.
- FIFO: circular, DEPTH entries, with read/write pointers wrapping at DEPTH.
- opBus shows the head entry while setCount>0, else 0. It is stable from START through the end of BUSY.
- FSM:
  - IDLE: if setCount>0, go to START.
  - START: startFP=1 for exactly one cycle; go to BUSY.
  - BUSY: busy=1. On doneFP=1, pop the head (setCount-1) and go to IDLE.
  - doneFP is ignored in IDLE and START.
- Latency: final beat sampled at edge k → setCount=1 after edge k → START (startFP high) between edges k+1 and k+2 → BUSY from edge k+2.
- Back-to-back: with the pop at edge m and more sets queued, IDLE after m, START after m+1. There is a minimum of 2 cycles between startFP pulses.
- Simultaneous push and pop on the same edge: setCount is unchanged and both pointers advance.
  - Because inAccept is registered-derived, a pop while full raises inAccept only in the following cycle.
- doneFP held high across several cycles: one pop per BUSY visit.
- Overflow and underflow are impossible by construction. There is no push when setCount=DEPTH, and no pop outside BUSY.

Test Plan:
1. Defaults. Send 0x42FA4000 then 0x41410000 with inReady=1. Expect opBus={0x41410000,0x42FA4000}; startFP high for exactly one cycle, 2 edges after the second capture; busy=1 until doneFP; then setCount=0 and opBus=0.
2. BUS_W=16. Send beats 0x42FA, 0x4000, 0x4141, 0x0000 with inReady gaps of 3 cycles between beats. Expect the same opBus as test 1, no capture during gaps, and one startFP pulse.
3. DEPTH=2, doneFP=0. Stream 3 sets. Expect setCount=2 and inAccept=0 after the 2nd set; the 3rd set's first beat is not captured. Pulse doneFP: setCount=1, inAccept=1 one cycle later, and the 3rd set is accepted.
4. Push and pop on the same edge. With one set in BUSY, align the final beat of set 2 with doneFP. Expect setCount stays 1, START follows 1 cycle after IDLE, and opBus shows set 2.
5. doneFP=1 in IDLE with setCount=0: no change. With 1 queued set, hold doneFP high for 3 cycles through START and BUSY: exactly one pop, and setCount ends at 0.
6. Assert rst for 1 cycle after 1 beat of set 2, while set 1 is in BUSY. Expect all outputs at reset values. The next 2 words (0x3F800000, 0x40000000) form a fresh set, with opBus={0x40000000,0x3F800000}.

Source files
------------

// File: rtl/fp_in_wrapper_param.sv
// Input wrapper for the FP datapath: assembles NUM_OPS operands from a serial
// BUS_W stream, queues up to DEPTH complete sets and issues them one at a time.
module fp_in_wrapper_param #(
    parameter int DATA_W  = 32,
    parameter int BUS_W   = 32,
    parameter int NUM_OPS = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inReady,
    input  logic [BUS_W-1:0]             inBus,
    input  logic                         doneFP,
    output logic                         inAccept,
    output logic [NUM_OPS*DATA_W-1:0]    opBus,
    output logic                         startFP,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   setCount
);

    localparam int BEATS   = DATA_W / BUS_W;
    localparam int SET_W   = NUM_OPS * DATA_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OP_CW   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BEAT_CW-1:0] r_beat;
    logic [OP_CW-1:0]   r_op;
    logic [SET_W-1:0]   r_asm;
    logic [SET_W-1:0]   w_set;
    logic [SET_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_capture;
    logic               w_last_beat;
    logic               w_last_op;
    logic               w_push;
    logic               w_pop;
    int                 w_lo;

    assign inAccept    = (r_count < CNT_W'(DEPTH));
    assign setCount    = r_count;
    assign opBus       = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign w_capture   = inReady & inAccept;
    assign w_last_beat = (r_beat == BEAT_CW'(BEATS - 1));
    assign w_last_op   = (r_op == OP_CW'(NUM_OPS - 1));
    assign w_push      = w_capture & w_last_beat & w_last_op;
    assign w_pop       = (r_state == S_BUSY) & doneFP;

    // First beat of an operand lands in its most significant slice.
    always_comb begin
        w_lo  = int'(r_op) * DATA_W + (BEATS - 1 - int'(r_beat)) * BUS_W;
        w_set = r_asm;
        w_set[w_lo +: BUS_W] = inBus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_op   <= '0;
            r_asm  <= '0;
        end else if (w_capture) begin
            r_asm <= w_set;
            if (w_last_beat) begin
                r_beat <= '0;
                r_op   <= w_last_op ? '0 : r_op + 1'b1;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // doneFP only matters in BUSY, so a held doneFP retires one set per visit.
    always_comb begin
        w_next  = r_state;
        startFP = 1'b0;
        busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_next = S_START;
            end
            S_START: begin
                startFP = 1'b1;
                w_next  = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (doneFP) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
